port_in_debounce: RTL and testbench
===================================

# port_in_debounce

Input conditioning stage in front of the GPIO ports of the MCU subsystem. It takes raw asynchronous board inputs (switches, buttons, external pins) and synchronises them to HCLK. It then debounces each bit and drives the stable value into the port input of the processor subsystem. It also produces per-bit rise/fall pulses and a sticky, maskable change-interrupt summary for the NVIC/wake-up path.

## Interface
- WIDTH, 8: number of input bits.
- PRESCALE, 1000: HCLK cycles per sample tick; legal range is 1 or more.
- STABLE_TICKS, 4: consecutive ticks of a differing value needed before the output changes; legal range is 1 or more.
- RESET_VAL, {WIDTH{1'b0}}: reset value of the sync flops and PORT_IN.
- HCLK  in  1  system clock; the only clock.
- HRESETn  in  1  reset, synchronous, active-low, sampled on the HCLK rising edge.
- PIN_IN  in  WIDTH  raw asynchronous inputs.
- BYPASS  in  1  test/debug bypass, tied to TESTMODE at top level. When 1, debounce is skipped.
- IRQ_EN  in  WIDTH  per-bit interrupt enable.
- IRQ_CLR  in  WIDTH  per-bit clear of the sticky status; single-cycle pulses.
- PORT_IN  out  WIDTH  debounced value, registered.
- RISE  out  WIDTH  one-cycle pulse when a PORT_IN bit goes 0→1.
- FALL  out  WIDTH  one-cycle pulse when a PORT_IN bit goes 1→0.
- CHG_STS  out  WIDTH  sticky per-bit change status.
- CHG_IRQ  out  1  OR-reduction of CHG_STS, registered.

## Operation
- **Synchroniser.** Two flop stages per bit, s1 then s2. Stage s2 is the synchronised value `sync[i]`.
- **Prescaler.**
  - Counter `pcnt` counts 0..PRESCALE-1 and wraps to 0.
  - `tick` is high in the cycle where pcnt==PRESCALE-1.
  - With PRESCALE=1, tick is high every cycle.
- **Per-bit debounce counter** `cnt[i]`, width clog2(STABLE_TICKS+1):
  - If sync[i]==PORT_IN[i], cnt[i] is set to 0. This is evaluated every cycle, not only on tick, so any sample agreeing with the output aborts a pending change.
  - Otherwise, on tick:
    - If cnt[i]==STABLE_TICKS-1: PORT_IN[i] is set to sync[i] and cnt[i] is set to 0.
    - Else cnt[i] is incremented.
  - Otherwise, when there is no tick, cnt[i] holds.
  - cnt[i] never exceeds STABLE_TICKS-1 and never wraps.
- **Bypass.**
  - BYPASS=1: PORT_IN is loaded from sync every cycle, all cnt are held at 0, and the prescaler keeps running.
  - BYPASS changing mid-operation needs no special handling. A pending count is discarded because cnt is cleared.
- **Edge pulses.**
  - RISE[i] and FALL[i] are registered and asserted in the same cycle PORT_IN[i] takes its new value.
  - They are high for exactly one cycle per change, never both on the same bit.
- **Status.**
  - CHG_STS[i] is set when (RISE[i]|FALL[i]) & IRQ_EN[i].
  - CHG_STS[i] is cleared by IRQ_CLR[i].
  - If set and clear occur in the same cycle, set wins.
  - IRQ_EN deasserting does not clear existing status.
- **CHG_IRQ** is registered from |CHG_STS. It is one cycle behind CHG_STS.

## Timing
- **Reset** (HRESETn=0 at an HCLK edge) sets the following, all taking effect the same edge:
  - s1, s2 = RESET_VAL.
  - PORT_IN = RESET_VAL.
  - pcnt = 0.
  - All cnt = 0.
  - RISE = 0, FALL = 0.
  - CHG_STS = 0, CHG_IRQ = 0.
- **Reset mid-debounce** discards the pending change. No edge pulse is generated at reset release.
- **Debounced latency:**
  - The synchroniser adds 2 cycles.
  - The output then changes on the STABLE_TICKS-th tick of continuous disagreement, becoming visible the following cycle.
  - Total latency from a PIN_IN step: between 2+(STABLE_TICKS-1)·PRESCALE+1 and 2+STABLE_TICKS·PRESCALE cycles.
- **Bypass latency** is 3 cycles from PIN_IN to PORT_IN: 2 sync stages plus the output register.
- **Rejected pulses.** A PIN_IN pulse shorter than (STABLE_TICKS-1)·PRESCALE cycles never reaches PORT_IN. No RISE/FALL is generated for it.
- **Independence.** Bits are independent; simultaneous changes on several bits produce simultaneous pulses.
- **Interrupt latency.** CHG_STS is set 1 cycle after the RISE/FALL pulse. CHG_IRQ follows 1 cycle later.

## Test plan
All scenarios use WIDTH=8, PRESCALE=4, STABLE_TICKS=3, RESET_VAL=0.

1. **Clean step.**
   - Stimulus: PIN_IN[0] goes 0→1 and is held.
   - Required: PORT_IN[0]=1 first seen 11..14 cycles after the step; RISE[0] high for exactly 1 cycle in that same cycle; FALL stays 0.
2. **Glitch rejection.**
   - Stimulus: PIN_IN[3] high for 6 cycles, then back to 0.
   - Required: PORT_IN[3] stays 0; RISE and FALL stay 0; cnt[3] returns to 0.
3. **Bypass.**
   - Stimulus: BYPASS=1, PIN_IN=8'hA5 applied.
   - Required: PORT_IN=8'hA5 exactly 3 cycles later; RISE=8'hA5 for 1 cycle.
   - Then, PIN_IN=8'h00: PORT_IN=8'h00 after 3 cycles; FALL=8'hA5 for 1 cycle.
4. **Sticky status and clear.**
   - Setup: IRQ_EN=8'h01.
   - Stimulus: rise on bit 0 and bit 1 at the same time.
   - Required: CHG_STS=8'h01; CHG_IRQ=1 one cycle later.
   - Then, IRQ_CLR=8'h01 pulsed: CHG_STS=0; CHG_IRQ=0 one cycle later.
   - Then, an IRQ_CLR[0] pulse coinciding with a new FALL[0]: CHG_STS[0] stays 1.
5. **Reset mid-operation.**
   - Stimulus: PIN_IN=8'hFF held for 8 cycles, then HRESETn=0 for 1 cycle.
   - Required: all outputs are 0 on the next edge. PORT_IN reaches 8'hFF only 11..14 cycles after reset release, with RISE=8'hFF then.
6. **Edge case PRESCALE=1, STABLE_TICKS=1.**
   - Stimulus: PIN_IN[7] step.
   - Required: PORT_IN[7] changes exactly 3 cycles after the step.

Source files
------------

// File: rtl/port_in_debounce.sv
`default_nettype none
// ============================================================================
// Module   : port_in_debounce
// Purpose  : GPIO input conditioning. Synchronises raw pins to HCLK, debounces
//            each bit, and flags rise/fall edges with a sticky change IRQ.
// Revision : 1.0  initial release
// ============================================================================
module port_in_debounce #(
   parameter int               WIDTH        = 8,
   parameter int               PRESCALE     = 1000,
   parameter int               STABLE_TICKS = 4,
   parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [WIDTH-1:0] PIN_IN,
   input  logic             BYPASS,
   input  logic [WIDTH-1:0] IRQ_EN,
   input  logic [WIDTH-1:0] IRQ_CLR,
   output logic [WIDTH-1:0] PORT_IN,
   output logic [WIDTH-1:0] RISE,
   output logic [WIDTH-1:0] FALL,
   output logic [WIDTH-1:0] CHG_STS,
   output logic             CHG_IRQ
);

   localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CNT_W  = $clog2(STABLE_TICKS + 1);

   localparam logic [PCNT_W-1:0] C_PCNT_MAX = PCNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0]  C_CNT_MAX  = CNT_W'(STABLE_TICKS - 1);

   generate
      if (PRESCALE < 1 || STABLE_TICKS < 1) begin : g_bad_param
         $error("port_in_debounce: PRESCALE and STABLE_TICKS must be >= 1");
      end
   endgenerate

   logic [WIDTH-1:0]            r_s1;
   logic [WIDTH-1:0]            r_s2;
   logic [PCNT_W-1:0]           r_pcnt;
   logic                        w_tick;
   logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0]            r_port;
   logic [WIDTH-1:0]            w_port_nxt;
   logic [WIDTH-1:0]            r_rise;
   logic [WIDTH-1:0]            r_fall;
   logic [WIDTH-1:0]            w_rise_nxt;
   logic [WIDTH-1:0]            w_fall_nxt;
   logic [WIDTH-1:0]            r_sts;
   logic [WIDTH-1:0]            w_sts_nxt;
   logic                        r_irq;

   // Two-flop synchroniser; r_s2 is the only copy of the pins used downstream.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_s1 <= RESET_VAL;
         r_s2 <= RESET_VAL;
      end else begin
         r_s1 <= PIN_IN;
         r_s2 <= r_s1;
      end
   end

   // Sample-tick prescaler keeps running in bypass so leaving bypass is seamless.
   assign w_tick = (r_pcnt == C_PCNT_MAX);

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   // Agreement with the output clears the count on any cycle, not just ticks,
   // so a single agreeing sample aborts a pending change.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_port_nxt = r_port;
      for (int i = 0; i < WIDTH; i++) begin
         if (BYPASS) begin
            w_cnt_nxt[i]  = '0;
            w_port_nxt[i] = r_s2[i];
         end else if (r_s2[i] == r_port[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (w_tick) begin
            if (r_cnt[i] == C_CNT_MAX) begin
               w_cnt_nxt[i]  = '0;
               w_port_nxt[i] = r_s2[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
      w_rise_nxt = w_port_nxt & ~r_port;
      w_fall_nxt = ~w_port_nxt & r_port;
   end

   // Set has priority over clear so an edge landing on a clear is never lost.
   assign w_sts_nxt = ((r_rise | r_fall) & IRQ_EN) | (r_sts & ~IRQ_CLR);

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_cnt  <= '0;
         r_port <= RESET_VAL;
         r_rise <= '0;
         r_fall <= '0;
         r_sts  <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_port <= w_port_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
         r_sts  <= w_sts_nxt;
         r_irq  <= |r_sts;
      end
   end

   assign PORT_IN = r_port;
   assign RISE    = r_rise;
   assign FALL    = r_fall;
   assign CHG_STS = r_sts;
   assign CHG_IRQ = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_port_in_debounce.sv
`default_nettype none
// Testbench for port_in_debounce: table-driven bypass/status vectors plus
// hand-written debounce, glitch, reset and minimum-parameter sequences.
`timescale 1ns/1ps
module tb_port_in_debounce;

   logic       hclk = 1'b0;
   logic       hresetn;
   logic       bypass;
   logic [7:0] pin_in, irq_en, irq_clr;
   logic [7:0] port_in, rise, fall, chg_sts;
   logic       chg_irq;

   logic [7:0] pin2;
   logic       bypass2;
   logic [7:0] irq_en2, irq_clr2;
   logic [7:0] port2, rise2, fall2, sts2;
   logic       irq2;

   always #5 hclk = ~hclk;

   port_in_debounce #(.WIDTH(8), .PRESCALE(4), .STABLE_TICKS(3), .RESET_VAL(8'h00)) dut (
      .HCLK(hclk), .HRESETn(hresetn), .PIN_IN(pin_in), .BYPASS(bypass),
      .IRQ_EN(irq_en), .IRQ_CLR(irq_clr), .PORT_IN(port_in), .RISE(rise),
      .FALL(fall), .CHG_STS(chg_sts), .CHG_IRQ(chg_irq)
   );

   port_in_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_TICKS(1), .RESET_VAL(8'h00)) dut2 (
      .HCLK(hclk), .HRESETn(hresetn), .PIN_IN(pin2), .BYPASS(bypass2),
      .IRQ_EN(irq_en2), .IRQ_CLR(irq_clr2), .PORT_IN(port2), .RISE(rise2),
      .FALL(fall2), .CHG_STS(sts2), .CHG_IRQ(irq2)
   );

   typedef struct packed {
      logic [7:0] pin, en, clr;
      logic [7:0] port, rise, fall, sts;
      logic       irq;
   } vec_t;

   vec_t vecs [23];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         lat;
      logic [7:0] pre_pulse;
      logic [7:0] bad_port;
      logic [7:0] pulses;

      //           pin    en     clr    port   rise   fall   sts    irq
      vecs[0]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0};
      vecs[3]  = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[5]  = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0};
      vecs[7]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[9]  = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[10] = '{8'h03, 8'h01, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00, 1'b0};
      vecs[11] = '{8'h03, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b0};
      vecs[12] = '{8'h03, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b1};
      vecs[13] = '{8'h03, 8'h01, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[14] = '{8'h03, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[15] = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[16] = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[17] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 1'b0};
      vecs[18] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0};
      vecs[19] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
      vecs[20] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
      vecs[21] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[22] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

      hresetn = 1'b0; bypass = 1'b0; pin_in = 8'h00; irq_en = 8'h00; irq_clr = 8'h00;
      pin2 = 8'h00; bypass2 = 1'b0; irq_en2 = 8'h00; irq_clr2 = 8'h00;
      step();
      step();
      check("reset port_in", port_in, 8'h00);
      check("reset rise", rise, 8'h00);
      check("reset fall", fall, 8'h00);
      check("reset chg_sts", chg_sts, 8'h00);
      check("reset chg_irq", chg_irq, 1'b0);
      check("reset pcnt", dut.r_pcnt, 0);
      check("reset dut2 port", port2, 8'h00);

      // Bypass path and sticky status: fully deterministic, so table-driven.
      hresetn = 1'b1;
      bypass  = 1'b1;
      for (int k = 0; k < 23; k++) begin
         pin_in  = vecs[k].pin;
         irq_en  = vecs[k].en;
         irq_clr = vecs[k].clr;
         step();
         check($sformatf("vec%0d port_in", k), port_in, vecs[k].port);
         check($sformatf("vec%0d rise", k), rise, vecs[k].rise);
         check($sformatf("vec%0d fall", k), fall, vecs[k].fall);
         check($sformatf("vec%0d chg_sts", k), chg_sts, vecs[k].sts);
         check($sformatf("vec%0d chg_irq", k), chg_irq, vecs[k].irq);
      end
      bypass  = 1'b0;
      irq_clr = 8'h00;
      irq_en  = 8'h01;
      step();
      step();

      // Clean step on bit 0.
      pin_in = 8'h01;
      lat = 0; pre_pulse = 8'h00;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         step();
         if (port_in[0]) begin
            lat = n;
            check("t1 rise at change", rise, 8'h01);
            check("t1 fall at change", fall, 8'h00);
         end else begin
            pre_pulse |= rise | fall;
         end
      end
      check_rng("t1 step latency", lat, 11, 14);
      check("t1 early pulses", pre_pulse, 8'h00);
      step();
      check("t1 rise one cycle", rise, 8'h00);
      check("t1 chg_sts", chg_sts, 8'h01);
      check("t1 chg_irq lag", chg_irq, 1'b0);
      step();
      check("t1 chg_irq", chg_irq, 1'b1);

      // 6-cycle glitch on bit 3 must be rejected.
      pin_in = 8'h09;
      bad_port = 8'h01; pulses = 8'h00;
      for (int n = 0; n < 30; n++) begin
         if (n == 6) pin_in = 8'h01;
         step();
         if (port_in != 8'h01) bad_port = port_in;
         pulses |= rise | fall;
      end
      check("t2 port_in held", bad_port, 8'h01);
      check("t2 no pulses", pulses, 8'h00);
      check("t2 cnt3 cleared", dut.r_cnt[3], 0);

      // Reset in the middle of a pending change.
      pin_in = 8'hFF;
      repeat (8) step();
      check("t5 port before reset", port_in, 8'h01);
      hresetn = 1'b0;
      step();
      check("t5 reset port_in", port_in, 8'h00);
      check("t5 reset rise", rise, 8'h00);
      check("t5 reset fall", fall, 8'h00);
      check("t5 reset chg_sts", chg_sts, 8'h00);
      check("t5 reset chg_irq", chg_irq, 1'b0);
      hresetn = 1'b1;
      lat = 0; pre_pulse = 8'h00;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         step();
         if (port_in == 8'hFF) begin
            lat = n;
            check("t5 rise at change", rise, 8'hFF);
         end else begin
            pre_pulse |= rise | fall;
         end
      end
      check_rng("t5 latency after reset", lat, 11, 14);
      check("t5 no pulse at release", pre_pulse, 8'h00);
      step();
      step();
      check("t5 chg_sts", chg_sts, 8'h01);
      check("t5 chg_irq", chg_irq, 1'b1);

      // PRESCALE=1, STABLE_TICKS=1: exactly three cycles.
      pin2 = 8'h80;
      step();
      check("t6 cycle1 port", port2, 8'h00);
      step();
      check("t6 cycle2 port", port2, 8'h00);
      step();
      check("t6 cycle3 port", port2, 8'h80);
      check("t6 cycle3 rise", rise2, 8'h80);
      step();
      check("t6 rise one cycle", rise2, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
